// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the register file and its scoreboard.
package regfile_scoreboard_pkg;

   // Default data width and register count of the core register file
   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREGS = 32;

   // Register-address width for the default register count
   localparam int REG_AW    = $clog2(DEF_NREGS);

   // Address width for an arbitrary register count (at least one bit)
   function automatic int addr_width(input int nregs);
      return (nregs < 2) ? 1 : $clog2(nregs);
   endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_bits.sv
// Scoreboard: per-register busy bits, busy population count, sticky
// double-set error flag and hazard outputs for the two read ports.
module regfile_sb_bits
   import regfile_scoreboard_pkg::*;
#(
   parameter int NREGS    = DEF_NREGS,
   parameter int AW       = addr_width(NREGS),
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sb_set,
   input  logic [AW-1:0] sb_addr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic          busy1,
   output logic          busy2,
   output logic          sb_err,
   output logic [AW:0]   busy_cnt
);

   logic [NREGS-1:0] busy_reg;
   logic [AW:0]      cnt_reg;
   logic             err_reg;

   logic set_eff;
   logic clr_hits_set;
   logic cnt_inc;
   logic cnt_dec;
   logic err_hit;

   // Qualify the set request and work out the count delta for this edge
   always_comb begin
      set_eff      = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));
      clr_hits_set = clr_en && (clr_addr == sb_addr);
      cnt_inc      = set_eff && !busy_reg[sb_addr];
      cnt_dec      = clr_en && busy_reg[clr_addr] && !(set_eff && clr_hits_set);
      err_hit      = set_eff && busy_reg[sb_addr] && !clr_hits_set;
   end

   // One busy flop per register; a set wins over a clear on the same bit
   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               busy_reg[gi] <= 1'b0;
            else if (set_eff && (sb_addr == AW'(gi)))
               busy_reg[gi] <= 1'b1;
            else if (clr_en && (clr_addr == AW'(gi)))
               busy_reg[gi] <= 1'b0;
         end
      end
   endgenerate

   // Running population count of busy bits plus sticky error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
         err_reg <= 1'b0;
      end else begin
         cnt_reg <= cnt_reg + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
         if (err_hit)
            err_reg <= 1'b1;
      end
   end

   // Hazard view: a load writeback clearing the register this cycle hides
   // the busy bit unless a new set is landing on the same register
   always_comb begin
      busy1 = busy_reg[ra1];
      busy2 = busy_reg[ra2];
      if ((BYPASS != 0) && clr_en && (clr_addr == ra1) && !(set_eff && (sb_addr == ra1)))
         busy1 = 1'b0;
      if ((BYPASS != 0) && clr_en && (clr_addr == ra2) && !(set_eff && (sb_addr == ra2)))
         busy2 = 1'b0;
   end

   assign sb_err   = err_reg;
   assign busy_cnt = cnt_reg;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read / two-write register file with optional write forwarding and a
// load-latency scoreboard. Port 1 (load writeback) wins address collisions
// and clears the scoreboard entry it writes.
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter  int XLEN     = DEF_XLEN,
   parameter  int NREGS    = DEF_NREGS,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int AW       = addr_width(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            busy1,
   output logic            busy2,
   input  logic            we0,
   input  logic [AW-1:0]   wa0,
   input  logic [XLEN-1:0] wd0,
   input  logic            we1,
   input  logic [AW-1:0]   wa1,
   input  logic [XLEN-1:0] wd1,
   input  logic            sb_set,
   input  logic [AW-1:0]   sb_addr,
   output logic            sb_err,
   output logic [AW:0]     busy_cnt
);

   logic [XLEN-1:0] regs [NREGS];

   logic wr0_ok;
   logic wr1_ok;

   // Register 0 is hardwired when ZERO_REG is enabled
   always_comb begin
      wr0_ok = we0 && !((ZERO_REG != 0) && (wa0 == '0));
      wr1_ok = we1 && !((ZERO_REG != 0) && (wa1 == '0));
   end

   // Data array; port 1 is written last so it wins a same-address collision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else begin
         if (wr0_ok)
            regs[wa0] <= wd0;
         if (wr1_ok)
            regs[wa1] <= wd1;
      end
   end

   function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
      logic [XLEN-1:0] val;
      val = regs[ra];
      if (BYPASS != 0) begin
         if (we1 && (wa1 == ra))
            val = wd1;
         else if (we0 && (wa0 == ra))
            val = wd0;
      end
      if ((ZERO_REG != 0) && (ra == '0))
         val = '0;
      return val;
   endfunction

   // Combinational read ports with optional same-cycle forwarding
   always_comb begin
      rd1 = read_port(ra1);
      rd2 = read_port(ra2);
   end

   regfile_sb_bits #(
      .NREGS    (NREGS),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .sb_set   (sb_set),
      .sb_addr  (sb_addr),
      .clr_en   (we1),
      .clr_addr (wa1),
      .ra1      (ra1),
      .ra2      (ra2),
      .busy1    (busy1),
      .busy2    (busy2),
      .sb_err   (sb_err),
      .busy_cnt (busy_cnt)
   );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a forwarding build and a
// non-forwarding build driven from the same stimulus.
module tb_regfile_scoreboard;

   logic        clk;
   logic        rst;
   logic [4:0]  ra1, ra2, wa0, wa1, sb_addr;
   logic        we0, we1, sb_set;
   logic [31:0] wd0, wd1;

   logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
   logic        busy1, busy2, busy1_nb, busy2_nb;
   logic        sb_err, sb_err_nb;
   logic [5:0]  busy_cnt, busy_cnt_nb;

   int pass_cnt = 0;
   int total    = 0;

   regfile_scoreboard dut (
      .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .busy1(busy1), .busy2(busy2), .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1), .sb_set(sb_set), .sb_addr(sb_addr),
      .sb_err(sb_err), .busy_cnt(busy_cnt)
   );

   regfile_scoreboard #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
      .busy1(busy1_nb), .busy2(busy2_nb), .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1), .sb_set(sb_set), .sb_addr(sb_addr),
      .sb_err(sb_err_nb), .busy_cnt(busy_cnt_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0 = 0; we1 = 0; sb_set = 0;
   endtask

   initial begin
      rst = 1; ra1 = 5; ra2 = 0; wa0 = 0; wa1 = 0; sb_addr = 0;
      we0 = 0; we1 = 0; sb_set = 0; wd0 = 0; wd1 = 0;
      #2;
      chk("reset_rd1", rd1, 32'h0);
      chk("reset_cnt", {26'b0, busy_cnt}, 32'd0);
      chk("reset_err", {31'b0, sb_err}, 32'd0);
      // writes presented while in reset must be dropped
      we0 = 1; wa0 = 5; wd0 = 32'h1234_5678;
      tick();
      tick();
      idle();
      rst = 0;
      #1;
      chk("rst_drop_write", rd1, 32'h0);

      // write r5 and mark r6 busy, then reset mid-cycle
      we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; sb_set = 1; sb_addr = 6;
      tick();
      idle();
      #1;
      chk("r5_written", rd1, 32'hDEADBEEF);
      chk("cnt_before_rst", {26'b0, busy_cnt}, 32'd1);
      rst = 1;
      #1;
      chk("async_rst_rd1", rd1, 32'h0);
      chk("async_rst_cnt", {26'b0, busy_cnt}, 32'd0);
      chk("async_rst_err", {31'b0, sb_err}, 32'd0);
      tick();
      rst = 0;

      // dual-write collision on r7
      we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; ra1 = 7;
      #1;
      chk("collide_bypass", rd1, 32'h22);
      chk("collide_nobypass", rd1_nb, 32'h0);
      tick();
      idle();
      #1;
      chk("collide_stored", rd1, 32'h22);
      chk("collide_stored_nb", rd1_nb, 32'h22);

      // zero register ignores writes and scoreboard sets
      we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; sb_set = 1; sb_addr = 0; ra1 = 0;
      #1;
      chk("zero_bypass", rd1, 32'h0);
      tick();
      idle();
      #1;
      chk("zero_read", rd1, 32'h0);
      chk("zero_busy", {31'b0, busy1}, 32'd0);
      chk("zero_cnt", {26'b0, busy_cnt}, 32'd0);
      chk("zero_err", {31'b0, sb_err}, 32'd0);

      // load hazard on r3
      sb_set = 1; sb_addr = 3;
      tick();
      idle();
      ra1 = 3;
      #1;
      chk("hazard_busy", {31'b0, busy1}, 32'd1);
      chk("hazard_cnt", {26'b0, busy_cnt}, 32'd1);
      tick();
      tick();
      we1 = 1; wa1 = 3; wd1 = 32'h55;
      #1;
      chk("hazard_clear_busy", {31'b0, busy1}, 32'd0);
      chk("hazard_fwd", rd1, 32'h55);
      chk("hazard_nb_busy", {31'b0, busy1_nb}, 32'd1);
      chk("hazard_nb_rd", rd1_nb, 32'h0);
      tick();
      idle();
      #1;
      chk("hazard_cnt_after", {26'b0, busy_cnt}, 32'd0);
      chk("hazard_busy_after", {31'b0, busy1}, 32'd0);
      chk("hazard_rd_after", rd1, 32'h55);

      // set and clear on the same register in one cycle
      sb_set = 1; sb_addr = 4; ra2 = 4;
      tick();
      idle();
      #1;
      chk("r4_busy", {31'b0, busy2}, 32'd1);
      chk("r4_cnt", {26'b0, busy_cnt}, 32'd1);
      sb_set = 1; sb_addr = 4; we1 = 1; wa1 = 4; wd1 = 32'h77;
      #1;
      chk("setclr_busy_now", {31'b0, busy2}, 32'd1);
      tick();
      idle();
      #1;
      chk("setclr_busy", {31'b0, busy2}, 32'd1);
      chk("setclr_err", {31'b0, sb_err}, 32'd0);
      chk("setclr_cnt", {26'b0, busy_cnt}, 32'd1);
      chk("setclr_data", rd2, 32'h77);
      sb_set = 1; sb_addr = 4;
      tick();
      idle();
      #1;
      chk("double_set_err", {31'b0, sb_err}, 32'd1);
      chk("double_set_cnt", {26'b0, busy_cnt}, 32'd1);
      // set r8 while clearing r4: net count change zero
      sb_set = 1; sb_addr = 8; we1 = 1; wa1 = 4; wd1 = 32'h88;
      tick();
      idle();
      ra1 = 8;
      #1;
      chk("swap_cnt", {26'b0, busy_cnt}, 32'd1);
      chk("swap_busy8", {31'b0, busy1}, 32'd1);
      chk("swap_busy4", {31'b0, busy2}, 32'd0);
      chk("err_sticky", {31'b0, sb_err}, 32'd1);
      tick();
      chk("err_sticky2", {31'b0, sb_err}, 32'd1);
      rst = 1;
      #1;
      chk("err_cleared", {31'b0, sb_err}, 32'd0);
      tick();
      rst = 0;

      // forwarding disabled: new data visible only after the edge
      we0 = 1; wa0 = 9; wd0 = 32'hAB; ra2 = 9;
      #1;
      chk("nb_old", rd2_nb, 32'h0);
      chk("b_fwd", rd2, 32'hAB);
      tick();
      idle();
      #1;
      chk("nb_new", rd2_nb, 32'hAB);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of 2, >=2); AW = clog2(NREGS) derived, not overridable.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads 0 and ignores writes and scoreboard sets.
REQ-004 SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to read ports.
REQ-005 SHALL have ports; one clock, reset asynchronous and active-high:
  clk  in  1  clock, all state updates on rising edge
  rst  in  1  asynchronous, active-high reset
  ra1, ra2  in  AW  read addresses
  rd1, rd2  out  XLEN  read data (combinational)
  busy1, busy2  out  1  scoreboard busy for ra1/ra2
  we0  in  1  write enable, port 0 (ALU writeback)
  wa0  in  AW  write address, port 0
  wd0  in  XLEN  write data, port 0
  we1  in  1  write enable, port 1 (load writeback; also clears busy)
  wa1  in  AW  write address, port 1
  wd1  in  XLEN  write data, port 1
  sb_set  in  1  mark register as pending long-latency write
  sb_addr  in  AW  register to mark busy
  sb_err  out  1  sticky: sb_set to an already-busy register
  busy_cnt  out  AW+1  number of busy registers

Function
REQ-006 SHALL update reg[wa0] <= wd0 when we0, reg[wa1] <= wd1 when we1, on rising clk.
REQ-007 SHALL, when we0 and we1 target the same address, write wd1 (port 1 wins).
REQ-008 SHALL, when ZERO_REG=1, drop writes to address 0 and return 0 for reads of address 0 regardless of bypass.
REQ-009 SHALL, when BYPASS=1, drive rdN = wd1 if we1 and wa1==raN, else wd0 if we0 and wa0==raN, else reg[raN]; when BYPASS=0, rdN = reg[raN] only.
REQ-010 SHALL set busy[sb_addr] on rising clk when sb_set (except address 0 when ZERO_REG=1).
REQ-011 SHALL clear busy[wa1] on rising clk when we1; we0 SHALL NOT affect busy.
REQ-012 SHALL, when sb_set and we1 hit the same address in one cycle, leave busy set (set wins).
REQ-013 SHALL drive busyN = busy[raN], forced 0 when BYPASS=1 and we1 with wa1==raN is clearing it that cycle and sb_set does not target raN.
REQ-014 SHALL set sb_err on rising clk when sb_set targets a register whose busy bit is 1 and not being cleared that cycle; sb_err stays 1 until reset.
REQ-015 SHALL keep busy_cnt equal to the population count of busy bits, registered, updated same edge as busy (+1, -1, or 0 net per cycle; set and clear of different addresses net 0).
REQ-016 SHALL treat out-of-range addresses as impossible (NREGS power of 2).

Reset
REQ-017 SHALL, while rst=1, immediately clear all registers to 0, all busy bits to 0, busy_cnt to 0, sb_err to 0.
REQ-018 SHALL drop writes and sb_set presented in a cycle where rst is asserted; first update on first rising clk after rst falls.

Structure
REQ-019 SHALL place default XLEN/NREGS and a common reg-address width constant in the shared core package, used by decode and hazard blocks.
REQ-020 SHALL implement the scoreboard (busy bits, busy_cnt, sb_err) as sub-module regfile_sb_bits, instantiated once; data array stays in the top.

Verification
REQ-021 Reset: write 0xDEADBEEF to r5, assert rst mid-cycle -> rd1 for ra1=5 reads 0 without clock edge; busy_cnt=0, sb_err=0.
REQ-022 Dual write collision: we0 wa0=7 wd0=0x11, we1 wa1=7 wd1=0x22 -> next cycle reg[7]=0x22; same cycle with BYPASS=1, ra1=7 gives 0x22.
REQ-023 Zero reg: we0 wa0=0 wd0=0xFFFFFFFF, sb_set sb_addr=0 -> ra1=0 reads 0, busy1=0, busy_cnt unchanged.
REQ-024 Load hazard: sb_set r3 -> busy1=1 for ra1=3, busy_cnt=1; 3 cycles later we1 wa1=3 wd1=0x55 -> same cycle busy1=0, rd1=0x55; next cycle busy_cnt=0.
REQ-025 Set/clear same address: busy[4]=1, sb_set r4 with we1 wa1=4 -> busy[4] stays 1, sb_err stays 0, busy_cnt unchanged; then sb_set r4 alone -> sb_err=1 persists until rst.
REQ-026 BYPASS=0 build: we0 wa0=9 wd0=0xAB, ra2=9 same cycle -> rd2 shows old value; next cycle 0xAB.
